// File: rtl/udp_rx_frame_parser.sv
// UDP receive-side frame parser: validates the one-word application header,
// forwards the payload as a keep-qualified stream and counts malformed frames.
module udp_rx_frame_parser #(
    parameter int          DATA_W  = 64,
    parameter logic [15:0] MAGIC   = 16'hA55A,
    parameter int          MAX_LEN = 1472
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [7:0]        m_keep,
    output logic              m_valid,
    output logic              m_last,
    output logic              m_user,
    input  logic              m_ready,
    output logic              hdr_valid,
    output logic [15:0]       hdr_seq,
    output logic [15:0]       hdr_len,
    output logic [7:0]        hdr_cmd,
    output logic [15:0]       err_hdr_cnt,
    output logic [15:0]       err_len_cnt,
    output logic [15:0]       seq_gap_cnt,
    output logic [15:0]       good_frame_cnt
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        run;
    logic [15:0] rem;
    logic        have_seq;
    logic [15:0] exp_seq;

    logic        accept, rem_le8, hdr_bad, len_zero;
    logic [15:0] f_magic, f_seq, f_len;
    logic [7:0]  f_cmd, f_chk, chk_calc;

    logic        hdr_pulse, rem_load, beat_load, beat_last, beat_user;
    logic        inc_hdr, inc_len, inc_good, inc_gap;
    logic [7:0]  beat_keep;

    assign f_magic  = s_data[15:0];
    assign f_seq    = s_data[31:16];
    assign f_len    = s_data[47:32];
    assign f_cmd    = s_data[55:48];
    assign f_chk    = s_data[63:56];
    assign chk_calc = s_data[7:0] ^ s_data[15:8] ^ s_data[23:16] ^ s_data[31:24]
                    ^ s_data[39:32] ^ s_data[47:40] ^ s_data[55:48];
    assign hdr_bad  = (f_magic != MAGIC) || (f_chk != chk_calc) || (f_len > 16'(MAX_LEN));
    assign len_zero = (f_len == 16'd0);
    assign accept   = s_valid && s_ready;
    assign rem_le8  = (rem <= 16'd8);

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
        return (en && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hdr_bad || s_last) state_nxt = s_last ? IDLE : DRAIN;
                    else if (len_zero)     state_nxt = DRAIN;
                    else                   state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (s_last)       state_nxt = IDLE;
                    else if (rem_le8) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept && s_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // run keeps s_ready low while reset is held and for the release cycle
    always_comb begin
        s_ready   = run && ((state != PAYLOAD) || !m_valid || m_ready);
        hdr_pulse = (state == IDLE) && accept && !hdr_bad && !(s_last && !len_zero);
        rem_load  = (state == IDLE) && accept && !hdr_bad && !s_last && !len_zero;
        beat_load = (state == PAYLOAD) && accept;
        beat_last = rem_le8 || s_last;
        beat_user = rem_le8 != s_last;
        beat_keep = rem_le8 ? (8'd1 << rem[3:0]) - 8'd1 : 8'hFF;
        if (rem >= 16'd8) beat_keep = 8'hFF;
        inc_hdr   = (state == IDLE) && accept && hdr_bad;
        inc_len   = ((state == IDLE) && accept && !hdr_bad && (s_last != len_zero))
                 || (beat_load && beat_user);
        inc_good  = ((state == IDLE) && accept && !hdr_bad && s_last && len_zero)
                 || (beat_load && rem_le8 && s_last);
        inc_gap   = hdr_pulse && have_seq && (f_seq != exp_seq);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            run            <= 1'b0;
            rem            <= '0;
            have_seq       <= 1'b0;
            exp_seq        <= '0;
            hdr_valid      <= 1'b0;
            hdr_seq        <= '0;
            hdr_len        <= '0;
            hdr_cmd        <= '0;
            m_data         <= '0;
            m_keep         <= '0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            m_user         <= 1'b0;
            err_hdr_cnt    <= '0;
            err_len_cnt    <= '0;
            seq_gap_cnt    <= '0;
            good_frame_cnt <= '0;
        end else begin
            run       <= 1'b1;
            hdr_valid <= hdr_pulse;
            if (hdr_pulse) begin
                hdr_seq  <= f_seq;
                hdr_len  <= f_len;
                hdr_cmd  <= f_cmd;
                have_seq <= 1'b1;
                exp_seq  <= f_seq + 16'd1;
            end
            if (rem_load)                  rem <= f_len;
            else if (beat_load && !rem_le8) rem <= rem - 16'd8;
            if (beat_load) begin
                m_data  <= s_data;
                m_keep  <= beat_keep;
                m_last  <= beat_last;
                m_user  <= beat_user;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            err_hdr_cnt    <= sat_inc(err_hdr_cnt, inc_hdr);
            err_len_cnt    <= sat_inc(err_len_cnt, inc_len);
            seq_gap_cnt    <= sat_inc(seq_gap_cnt, inc_gap);
            good_frame_cnt <= sat_inc(good_frame_cnt, inc_good);
        end
    end

endmodule

// File: doc/udp_rx_frame_parser.md
# udp_rx_frame_parser

- Sits directly downstream of the UDP receive path, in the sys_clk domain.
- Consumes the 64-bit little-endian word stream (`dout_data/valid/last/ready`), where the last word of a datagram is zero-padded.
- Treats word 0 of each datagram as an application header: validates magic, checksum, length and sequence, then publishes the header fields.
- Forwards the payload as a keep-qualified AXI-style stream, trims padding using the header length, and flags and counts malformed frames.

## Interface
- `DATA_W`, 64: word width; only 64 is supported because the header occupies one full word.
- `MAGIC`, 16'hA55A: required header magic.
- `MAX_LEN`, 1472: largest legal payload length, in bytes.
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `s_data` in 64: word from the UDP receive path; byte k is `[8k+7:8k]`.
- `s_valid` in 1: word valid.
- `s_last` in 1: last word of the datagram.
- `s_ready` out 1: word accepted when `s_valid && s_ready`.
- `m_data` out 64: payload word.
- `m_keep` out 8: byte enables; all ones except possibly on the last beat.
- `m_valid` out 1: payload beat valid.
- `m_last` out 1: last payload beat of the frame.
- `m_user` out 1: frame error, meaningful only when `m_last` = 1.
- `m_ready` in 1: downstream accept.
- `hdr_valid` out 1: one-cycle pulse carrying a good header.
- `hdr_seq` out 16: header sequence field.
- `hdr_len` out 16: header length field.
- `hdr_cmd` out 8: header command field.
- `err_hdr_cnt` out 16: header-error count, saturating.
- `err_len_cnt` out 16: length-error count, saturating.
- `seq_gap_cnt` out 16: sequence-discontinuity count, saturating.
- `good_frame_cnt` out 16: count of frames completed without error, saturating.

## Operation
- Header word layout:
  - `[15:0]` magic
  - `[31:16]` seq
  - `[47:32]` len
  - `[55:48]` cmd
  - `[63:56]` chk, where chk = XOR of bytes 0..6.
- **IDLE:**
  - `s_ready` = 1.
  - On header accept:
    - If magic ≠ MAGIC, chk is bad, or len > MAX_LEN: this is a header error. `err_hdr_cnt`+1 and no `hdr_valid`. Go to DRAIN if `s_last` = 0, else stay in IDLE.
    - Else if `s_last` = 1 and len > 0: this is a length error. `err_len_cnt`+1, no `hdr_valid`, stay in IDLE.
    - Else if `s_last` = 0 and len = 0: this is a length error. Pulse `hdr_valid`, `err_len_cnt`+1, go to DRAIN.
    - Else if `s_last` = 1 and len = 0: pulse `hdr_valid`, `good_frame_cnt`+1, stay in IDLE. No payload beats are emitted.
    - Otherwise: pulse `hdr_valid`, load `rem` = len, go to PAYLOAD.
  - Sequence check on every `hdr_valid`: if a previous good header exists and seq ≠ `exp_seq`, `seq_gap_cnt`+1. Then `exp_seq` = seq + 1, mod 2^16.
- **PAYLOAD:**
  - `s_ready` = !`m_valid` || `m_ready`.
  - Each accepted word is loaded into the output register with `m_keep` = (1 << min(`rem`, 8)) − 1.
  - `rem` ≤ 8 and `s_last` = 1: `m_last` = 1, `m_user` = 0, `good_frame_cnt`+1, go to IDLE.
  - `rem` ≤ 8 and `s_last` = 0 (datagram too long): `m_last` = 1, `m_user` = 1, `err_len_cnt`+1, go to DRAIN.
  - `rem` > 8 and `s_last` = 1 (datagram too short): `m_last` = 1, `m_user` = 1, `err_len_cnt`+1, go to IDLE.
  - `rem` > 8 and `s_last` = 0: `rem` −= 8, stay in PAYLOAD.
- **DRAIN:**
  - `s_ready` = 1; words are discarded.
  - On accepting `s_last` = 1, go to IDLE.
- Arithmetic:
  - `rem` is 16 bits and never underflows.
  - Counters saturate at 16'hFFFF.
  - Counters that increment in the same cycle increment independently.

## Timing
- Reset values:
  - All outputs are 0, including `hdr_*`, `m_*` and all counters.
  - State = IDLE.
  - No previous sequence is recorded.
  - `s_ready` = 1 one cycle after reset is released.
- Latency:
  - Accepted payload word → `m_valid` on the next cycle.
  - Header accept → `hdr_valid` and `hdr_*` on the next cycle.
  - `hdr_*` hold their value until the next good header.
  - `hdr_valid` of a frame always precedes its first payload beat by ≥ 1 cycle.
- Throughput: 1 word/cycle while `m_ready` = 1.
- Output handshake: while `m_valid` && !`m_ready`, `m_data`, `m_keep`, `m_last` and `m_user` are held stable.
- Input handshake: `s_ready` depends only on state, `m_valid` and `m_ready`; it never depends on `s_valid`.
- IDLE → PAYLOAD: the first payload word may be accepted on the cycle immediately after the header.
- A new header may be accepted in the cycle after the last payload word, even while that beat is still stalled at the output.
- `sys_rst_n` asserted mid-frame:
  - Abandon the frame, clear `m_valid`, and clear all counters.
  - The next accepted word is treated as a header.

## Test plan
- **Good frame:** header magic A55A, seq 5, len 20, cmd 3, correct chk; 3 payload words, the third with `s_last`. Required:
  - `hdr_valid` pulse with seq 5, len 20, cmd 3.
  - 3 beats with `m_keep` FF, FF, 0F.
  - `m_last` on beat 3, `m_user` 0, `good_frame_cnt` = 1.
- **Backpressure:** same frame with `m_ready` toggling 1/0 every cycle. Required:
  - Identical beats, each held stable while stalled.
  - No word lost or duplicated.
- **Bad checksum:** bad chk, 4 trailing words. Required:
  - All words consumed, no `hdr_valid`, no beats, `err_hdr_cnt` = 1.
  - A following good frame passes unchanged.
- **Short and long datagrams:**
  - len 24 with only 2 payload words: beat 2 has `m_last` = 1, `m_user` = 1, `m_keep` FF; `err_len_cnt` = 1.
  - len 8 with 3 payload words: beat 1 has `m_last` = 1, `m_user` = 1; the remaining 2 words are drained; `err_len_cnt` = 2.
- **Sequence gap:** good frames with seq FFFF, 0000, 0002. Required:
  - No increment at 0000 (wrap-around).
  - `seq_gap_cnt` = 1 after 0002.
- **Zero-length frame and reset:**
  - Single header word with len 0 and `s_last`: `hdr_valid` pulse, no beats, `good_frame_cnt` +1.
  - Then `sys_rst_n` = 0 for 1 cycle mid-PAYLOAD: all counters 0, `m_valid` 0, and the next word is parsed as a header.
